// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: buffers left/right samples and serialises them as a standard I2S stream
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int BCLK_DIV     = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] audio,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    underrun
);
  localparam int SW = $clog2(2 * SAMPLE_WIDTH);
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(2 * SAMPLE_WIDTH - 1);
  localparam logic [SW-1:0] S_RIGHT  = SW'(SAMPLE_WIDTH);
  localparam logic [SW-1:0] S_WS_BEG = SW'(SAMPLE_WIDTH - 1);
  localparam logic [SW-1:0] S_WS_END = SW'(2 * SAMPLE_WIDTH - 2);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    bclk_q, bclk_d;
  logic [SW-1:0]           s_q, s_d;
  logic                    lrclk_q, lrclk_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    underrun_q, underrun_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [PW-1:0]           rd_q, rd_d;
  logic [PW-1:0]           wr_q, wr_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                    tc;
  logic                    fall;
  logic                    load;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Free-running bit clock divider and slot counter; slot state only moves on falling events.
  always_comb begin
    tc      = cnt_q == CNT_LAST;
    cnt_d   = tc ? '0 : cnt_q + CW'(1);
    bclk_d  = tc ? ~bclk_q : bclk_q;
    fall    = tc && bclk_q;
    s_d     = !fall ? s_q : (s_q == S_LAST) ? '0 : s_q + SW'(1);
    load    = fall && (s_d == '0 || s_d == S_RIGHT);
    lrclk_d = fall ? (s_d >= S_WS_BEG && s_d <= S_WS_END) : lrclk_q;
  end

  // Sample FIFO: push on handshake, pop only when a slot load finds data waiting.
  always_comb begin
    empty       = occ_q == '0;
    audio_ready = occ_q < OCC_FULL;
    push        = audio_valid && audio_ready;
    pop         = load && !empty;
    occ_d       = occ_q + OW'(push) - OW'(pop);
    wr_d        = wr_q + PW'(push);
    rd_d        = rd_q + PW'(pop);
    mem_d       = mem_q;
    if (push) mem_d[wr_q] = audio;
  end

  // Output shifter: load the FIFO head (or silence) at slot start, else shift MSB-first.
  always_comb begin
    shift_d    = load ? (empty ? '0 : mem_q[rd_q]) : fall ? {shift_q[SAMPLE_WIDTH-2:0], 1'b0} : shift_q;
    underrun_d = load && empty;
  end

  // State registers; reset parks the slot counter so the first falling event starts the left slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      bclk_q     <= 1'b0;
      s_q        <= S_LAST;
      lrclk_q    <= 1'b0;
      shift_q    <= '0;
      underrun_q <= 1'b0;
      occ_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      mem_q      <= '{default: '0};
    end else begin
      cnt_q      <= cnt_d;
      bclk_q     <= bclk_d;
      s_q        <= s_d;
      lrclk_q    <= lrclk_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      occ_q      <= occ_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = shift_q[SAMPLE_WIDTH-1];
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed scenarios against an I2S receiver model
module tb_audio_i2s_tx;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] audio = '0;
  logic        audio_valid = 1'b0;
  logic        audio_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rx_w [$];
  int          ur_q [$];
  int          m_slot = 63;
  int          m_frame = -1;
  logic        m_prev = 1'b0;
  logic [31:0] m_word = '0;
  logic [63:0] lr_bits = '0;

  audio_i2s_tx #(.SAMPLE_WIDTH(32), .BCLK_DIV(2), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .audio(audio), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .underrun(underrun)
  );

  always #5 clock = ~clock;

  // Receiver: counts slots from bit clock falling edges, assembles words, logs underrun slots.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_slot = 63;
      m_frame = -1;
      m_prev = 1'b0;
      m_word = '0;
      lr_bits = '0;
      rx_w.delete();
      ur_q.delete();
    end else begin
      if (m_prev && !i2s_bclk) begin
        m_slot = (m_slot == 63) ? 0 : m_slot + 1;
        if (m_slot == 0) m_frame++;
        if (m_frame == 0) lr_bits[m_slot] = i2s_lrclk;
        m_word = {m_word[30:0], i2s_sdata};
        if (m_slot == 31 || m_slot == 63) rx_w.push_back(m_word);
      end
      if (underrun) ur_q.push_back(m_frame * 64 + m_slot);
      m_prev = i2s_bclk;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [31:0] get_w(int i);
    return (i < rx_w.size()) ? rx_w[i] : 32'hdead_beef;
  endfunction

  function automatic int get_u(int i);
    return (i < ur_q.size()) ? ur_q[i] : -1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    audio_valid = 1'b0;
    audio = '0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (rx_w.size() < n && c < 3000) begin
      tick();
      c++;
    end
    checks++;
    if (rx_w.size() < n) begin
      errors++;
      $display("FAIL wait_words: got %0d words, required %0d", rx_w.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] bpat = 8'b0110_0110;
    reset_n = 1'b0;
    audio_valid = 1'b0;
    tick();
    tick();
    checks += 5;
    if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b required 0", i2s_bclk); end
    if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL rst_lrclk: got %b required 0", i2s_lrclk); end
    if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b required 0", i2s_sdata); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", underrun); end
    if (audio_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", audio_ready); end
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (i2s_bclk !== bpat[e-1]) begin
        errors++;
        $display("FAIL bclk_cycle%0d: got %b required %b", e, i2s_bclk, bpat[e-1]);
      end
    end
    wait_words(2);
    checks += 4;
    if (get_w(0) !== 32'h0) begin errors++; $display("FAIL idle_left: got %h required 0", get_w(0)); end
    if (get_w(1) !== 32'h0) begin errors++; $display("FAIL idle_right: got %h required 0", get_w(1)); end
    if (ur_q.size() != 2 || get_u(0) != 0) begin
      errors++;
      $display("FAIL idle_ur_left: got n=%0d first=%0d required n=2 first=0", ur_q.size(), get_u(0));
    end
    if (get_u(1) != 32) begin errors++; $display("FAIL idle_ur_right: got %0d required 32", get_u(1)); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (lr_bits[i] !== (i >= 31 && i <= 62)) begin
        errors++;
        $display("FAIL lrclk_slot%0d: got %b required %b", i, lr_bits[i], (i >= 31 && i <= 62));
      end
    end
  endtask

  task automatic test_stereo();
    apply_reset();
    audio = 32'h8000_0001;
    audio_valid = 1'b1;
    tick();
    audio = 32'h7FFF_FFFE;
    tick();
    audio_valid = 1'b0;
    wait_words(2);
    checks += 3;
    if (get_w(0) !== 32'h8000_0001) begin errors++; $display("FAIL stereo_left: got %h required 80000001", get_w(0)); end
    if (get_w(1) !== 32'h7FFF_FFFE) begin errors++; $display("FAIL stereo_right: got %h required 7ffffffe", get_w(1)); end
    if (ur_q.size() != 0) begin errors++; $display("FAIL stereo_underrun: got %0d pulses required 0", ur_q.size()); end
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    int iter = 0;
    apply_reset();
    while (nxt < 6 && iter < 2000) begin
      audio = 32'(nxt);
      audio_valid = 1'b1;
      if (iter < 2) begin
        checks++;
        if (audio_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b required 1", iter, audio_ready); end
      end
      if (iter == 2) begin
        checks++;
        if (audio_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b required 0", audio_ready); end
      end
      if (audio_ready) nxt++;
      tick();
      iter++;
    end
    audio_valid = 1'b0;
    wait_words(6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (get_w(i) !== 32'(i)) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, get_w(i), 32'(i)); end
    end
    checks++;
    if (ur_q.size() != 0) begin errors++; $display("FAIL b2b_underrun: got %0d pulses required 0", ur_q.size()); end
  endtask

  task automatic test_underrun();
    int c = 0;
    apply_reset();
    audio = 32'h1234_5678;
    audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    while (ur_q.size() == 0 && c < 3000) begin
      tick();
      c++;
    end
    audio = 32'hCAFE_F00D;
    audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    wait_words(4);
    checks += 6;
    if (get_w(0) !== 32'h1234_5678) begin errors++; $display("FAIL ur_left: got %h required 12345678", get_w(0)); end
    if (get_w(1) !== 32'h0) begin errors++; $display("FAIL ur_right: got %h required 0", get_w(1)); end
    if (get_w(2) !== 32'hCAFE_F00D) begin errors++; $display("FAIL ur_next_left: got %h required cafef00d", get_w(2)); end
    if (get_w(3) !== 32'h0) begin errors++; $display("FAIL ur_next_right: got %h required 0", get_w(3)); end
    if (ur_q.size() != 2 || get_u(0) != 32) begin
      errors++;
      $display("FAIL ur_first: got n=%0d first=%0d required n=2 first=32", ur_q.size(), get_u(0));
    end
    if (get_u(1) != 96) begin errors++; $display("FAIL ur_second: got %0d required 96", get_u(1)); end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    apply_reset();
    audio = 32'hAAAA_5555;
    audio_valid = 1'b1;
    tick();
    audio = 32'h5555_AAAA;
    tick();
    audio_valid = 1'b0;
    while (!(m_frame == 0 && m_slot == 33) && c < 3000) begin tick(); c++; end
    audio = 32'h1111_1111;
    audio_valid = 1'b1;
    tick();
    audio = 32'h2222_2222;
    tick();
    audio_valid = 1'b0;
    checks++;
    if (audio_ready !== 1'b0) begin errors++; $display("FAIL mid_buffered: got ready=%b required 0", audio_ready); end
    c = 0;
    while (!(m_frame == 0 && m_slot == 40) && c < 3000) begin tick(); c++; end
    checks++;
    if (i2s_lrclk !== 1'b1) begin errors++; $display("FAIL mid_slot40_lr: got %b required 1", i2s_lrclk); end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL mid_bclk: got %b required 0", i2s_bclk); end
    if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL mid_lrclk: got %b required 0", i2s_lrclk); end
    if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL mid_sdata: got %b required 0", i2s_sdata); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b required 0", underrun); end
    tick();
    tick();
    reset_n = 1'b1;
    checks++;
    if (audio_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", audio_ready); end
    wait_words(2);
    checks += 3;
    if (get_w(0) !== 32'h0) begin errors++; $display("FAIL mid_left: got %h required 0", get_w(0)); end
    if (get_w(1) !== 32'h0) begin errors++; $display("FAIL mid_right: got %h required 0", get_w(1)); end
    if (ur_q.size() != 2 || get_u(0) != 0 || get_u(1) != 32) begin
      errors++;
      $display("FAIL mid_ur: got n=%0d %0d,%0d required n=2 0,32", ur_q.size(), get_u(0), get_u(1));
    end
  endtask

  task automatic test_same_cycle_pop();
    apply_reset();
    audio = 32'hA5A5_0001;
    audio_valid = 1'b1;
    tick();
    audio_valid = 1'b0;
    tick();
    tick();
    audio = 32'h5A5A_0002;
    audio_valid = 1'b1;
    tick();
    checks++;
    if (audio_ready !== 1'b1) begin errors++; $display("FAIL sc_occ_one: got ready=%b required 1", audio_ready); end
    audio = 32'h0F0F_0003;
    tick();
    audio_valid = 1'b0;
    checks++;
    if (audio_ready !== 1'b0) begin errors++; $display("FAIL sc_occ_two: got ready=%b required 0", audio_ready); end
    wait_words(3);
    checks += 4;
    if (get_w(0) !== 32'hA5A5_0001) begin errors++; $display("FAIL sc_left: got %h required a5a50001", get_w(0)); end
    if (get_w(1) !== 32'h5A5A_0002) begin errors++; $display("FAIL sc_right: got %h required 5a5a0002", get_w(1)); end
    if (get_w(2) !== 32'h0F0F_0003) begin errors++; $display("FAIL sc_next: got %h required 0f0f0003", get_w(2)); end
    if (ur_q.size() != 0) begin errors++; $display("FAIL sc_underrun: got %0d pulses required 0", ur_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_back_to_back();
    test_underrun();
    test_mid_reset();
    test_same_cycle_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
